instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives the 8-bit word address to the instruction memory, which returns the 32-bit word combinationally in the same cycle.
- Registers the returned word into an IF/ID pipeline register and handles stalls, branch redirects and a halt sentinel.
- Sits between the instruction memory and the decode stage of the MIPS core.

---
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, and loads
// the IF/ID register. Handles stalls, branch redirects and a halt sentinel.
module instruction_fetch_unit #(
    parameter int                      PC_WIDTH    = 8,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = 32'hFFFF_FFFF,
    parameter int                      CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_valid,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [PC_WIDTH-1:0]     pc_nxt;
    logic [INSTR_WIDTH-1:0]  if_instr_nxt;
    logic [PC_WIDTH-1:0]     if_pc_nxt;
    logic                    if_valid_nxt;
    logic [CNT_WIDTH-1:0]    fetch_count_nxt;

    // State and IF/ID register; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_instr    <= '0;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_instr    <= if_instr_nxt;
            if_pc       <= if_pc_nxt;
            if_valid    <= if_valid_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    // Next-state decode: redirect beats stall, stall beats halt detect, halt beats fetch.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        if_instr_nxt    = if_instr;
        if_pc_nxt       = if_pc;
        if_valid_nxt    = if_valid;
        fetch_count_nxt = fetch_count;

        case (state)
            RUN: begin
                if (redirect) begin
                    // Squash the wrong-path word; the register contents are left as-is.
                    pc_nxt       = redirect_target;
                    if_valid_nxt = 1'b0;
                end else if (stall) begin
                    // Hold everything in place.
                end else if (instruction == HALT_WORD) begin
                    // Park on the halt address without delivering the sentinel.
                    state_nxt    = HALT;
                    if_valid_nxt = 1'b0;
                end else begin
                    if_instr_nxt    = instruction;
                    if_pc_nxt       = pc;
                    if_valid_nxt    = 1'b1;
                    pc_nxt          = pc + 1'b1;
                    fetch_count_nxt = fetch_count + 1'b1;
                end
            end
            HALT: begin
                if_valid_nxt = 1'b0;
                if (redirect) begin
                    pc_nxt    = redirect_target;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed vectors push their
// hand-computed post-edge expectations; a monitor pops and compares after each edge.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];

    typedef struct {
        logic [7:0]  pc;
        logic        v;
        logic [31:0] instr;
        logic [7:0]  ifpc;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .instruction     (instruction),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    // Combinational instruction memory
    assign instruction = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one vector at a negedge, queue its expected result, wait for the next negedge.
    task automatic apply(input logic st, input logic rd, input logic [7:0] tgt,
                         input logic [7:0] epc, input logic ev, input logic [31:0] einstr,
                         input logic [7:0] eifpc, input logic eh, input logic [15:0] ecnt);
        exp_t e;
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        e.pc = epc; e.v = ev; e.instr = einstr; e.ifpc = eifpc; e.halted = eh; e.cnt = ecnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},       {24'h0, pc},          32'h0);
        check({tag, "_if_instr"}, if_instr,             32'h0);
        check({tag, "_if_pc"},    {24'h0, if_pc},       32'h0);
        check({tag, "_if_valid"}, {31'h0, if_valid},    32'h0);
        check({tag, "_halted"},   {31'h0, halted},      32'h0);
        check({tag, "_count"},    {16'h0, fetch_count}, 32'h0);
    endtask

    // Monitor: one expectation per queued edge, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",          {24'h0, pc},          {24'h0, e.pc});
                check("if_valid",    {31'h0, if_valid},    {31'h0, e.v});
                check("halted",      {31'h0, halted},      {31'h0, e.halted});
                check("fetch_count", {16'h0, fetch_count}, {16'h0, e.cnt});
                if (e.v) begin
                    check("if_instr", if_instr,       e.instr);
                    check("if_pc",    {24'h0, if_pc}, {24'h0, e.ifpc});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'hAB00_0000 | a;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        mem[3] = 32'h44; mem[4] = 32'h55; mem[5] = 32'hFFFF_FFFF;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
        #12;
        check_reset_state("rst");

        @(negedge clk);
        rst_n = 1'b1;
        //     st rd tgt    pc     v  instr          ifpc   h  cnt
        apply(0, 0, 8'h00, 8'h01, 1, 32'h11,        8'h00, 0, 16'd1);
        apply(0, 0, 8'h00, 8'h02, 1, 32'h22,        8'h01, 0, 16'd2);
        apply(1, 0, 8'h00, 8'h02, 1, 32'h22,        8'h01, 0, 16'd2);
        apply(1, 0, 8'h00, 8'h02, 1, 32'h22,        8'h01, 0, 16'd2);
        apply(0, 0, 8'h00, 8'h03, 1, 32'h33,        8'h02, 0, 16'd3);
        apply(0, 0, 8'h00, 8'h04, 1, 32'h44,        8'h03, 0, 16'd4);
        apply(0, 0, 8'h00, 8'h05, 1, 32'h55,        8'h04, 0, 16'd5);
        apply(0, 0, 8'h00, 8'h05, 0, 32'h0,         8'h00, 1, 16'd5);
        apply(1, 0, 8'h00, 8'h05, 0, 32'h0,         8'h00, 1, 16'd5);
        apply(0, 1, 8'h00, 8'h00, 0, 32'h0,         8'h00, 0, 16'd5);
        apply(0, 0, 8'h00, 8'h01, 1, 32'h11,        8'h00, 0, 16'd6);
        apply(1, 1, 8'h80, 8'h80, 0, 32'h0,         8'h00, 0, 16'd6);
        apply(0, 0, 8'h00, 8'h81, 1, 32'hAB000080,  8'h80, 0, 16'd7);

        // Asynchronous reset mid-stream, well before the next rising edge
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("rst_hold");
        rst_n = 1'b1;

        apply(0, 1, 8'hFE, 8'hFE, 0, 32'h0,         8'h00, 0, 16'd0);
        apply(0, 0, 8'h00, 8'hFF, 1, 32'hAB0000FE,  8'hFE, 0, 16'd1);
        apply(0, 1, 8'hFF, 8'hFF, 0, 32'h0,         8'h00, 0, 16'd1);
        apply(0, 0, 8'h00, 8'h00, 1, 32'hAB0000FF,  8'hFF, 0, 16'd2);
        apply(0, 0, 8'h00, 8'h01, 1, 32'h11,        8'h00, 0, 16'd3);

        stall = 1'b1;
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
